// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter sharing one UART TX byte path among NUM_REQ requesters.
// A grant lasts until the message-final byte or MAX_BURST bytes, whichever comes first.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         grant_active,
  output logic                         burst_trunc
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_next;
  logic [GW-1:0]     ptr, ptr_next, gid_next, pick;
  logic [CW-1:0]     cnt, cnt_next;
  logic              any_req, hs, at_limit, trunc_next;
  logic [DATA_W-1:0] sel_data, data_p1;
  logic              vld_p1;

  // Index increment with explicit wrap so non-power-of-2 NUM_REQ stays in range.
  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
    if (idx == GW'(NUM_REQ - 1)) return '0;
    return idx + GW'(1);
  endfunction

  always_comb begin
    int idx;
    idx     = 0;
    pick    = ptr;
    any_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        pick    = GW'(idx);
      end
    end
  end

  assign sel_data = req_data[int'(grant_id)*DATA_W +: DATA_W];

  always_comb begin
    state_next = state;
    gid_next   = grant_id;
    ptr_next   = ptr;
    cnt_next   = cnt;
    req_ready  = '0;
    hs         = 1'b0;
    at_limit   = 1'b0;
    trunc_next = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gid_next   = pick;
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        hs                  = req_valid[grant_id] && (!vld_p1 || tx_ready);
        req_ready[grant_id] = hs;
        if (hs) begin
          cnt_next = cnt + CW'(1);
          at_limit = (cnt_next == CW'(MAX_BURST));
          if (req_last[grant_id] || at_limit) begin
            state_next = IDLE;
            ptr_next   = wrap_inc(grant_id);
            trunc_next = at_limit && !req_last[grant_id];
          end
        end
      end
    endcase
  end

  // Stage p1: one-entry output register toward the TX core
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state       <= IDLE;
      grant_id    <= '0;
      ptr         <= '0;
      cnt         <= '0;
      burst_trunc <= 1'b0;
      vld_p1      <= 1'b0;
      data_p1     <= '0;
    end else begin
      state       <= state_next;
      grant_id    <= gid_next;
      ptr         <= ptr_next;
      cnt         <= cnt_next;
      burst_trunc <= trunc_next;
      if (hs) begin
        data_p1 <= sel_data;
        vld_p1  <= 1'b1;
      end else if (tx_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign tx_data      = data_p1;
  assign tx_valid     = vld_p1;
  assign grant_active = (state == SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues drive the DUT; a transaction-level
// round-robin model predicts grant order, byte order and truncation count.
module tb_uart_tx_arbiter;
  localparam int N = 4, DW = 8, MB = 16, QD = 256, XD = 1024, TR = 2048;

  logic clk = 1'b0;
  logic rstn;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0]   tx_data;
  logic            tx_valid, tx_ready;
  logic [1:0]      grant_id;
  logic            grant_active, burst_trunc;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .ACLK(clk), .ARESETN(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .grant_active(grant_active), .burst_trunc(burst_trunc)
  );

  int total = 0, bad = 0;
  logic [7:0] qd [N][QD];
  bit         ql [N][QD];
  int         qh [N], qt [N];
  int         exp_id [XD];
  logic [7:0] exp_d  [XD];
  int         exp_n, exp_trunc;
  int         hs_k, tx_k, trunc_seen, cyc;
  int         hs_id [XD], hs_cyc [XD];
  bit         sb_en;
  logic       t_ga [TR], t_txv [TR], t_bt [TR];
  int         t_gid [TR];
  logic [7:0] t_txd [TR];
  logic [N-1:0] t_rdy [TR];
  bit         tr_rand;
  int         lo_s, lo_e, st_id, st_after, st_len, st_rem, st_cnt;
  bit         prev_hold;
  logic [7:0] prev_d;

  task automatic clear_ctl();
    for (int i = 0; i < N; i++) begin qh[i] = 0; qt[i] = 0; end
    tr_rand = 0; lo_s = 0; lo_e = 0;
    st_id = -1; st_after = 0; st_len = 0; st_rem = 0; st_cnt = 0;
    prev_hold = 0;
  endtask

  task automatic do_reset();
    clear_ctl();
    rstn = 1'b0;
    req_valid = N'($urandom); req_last = N'($urandom); req_data = $urandom;
    tx_ready = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    sb_en = 1;
  endtask

  task automatic push_byte(input int id, input logic [7:0] d, input bit l);
    qd[id][qt[id]] = d;
    ql[id][qt[id]] = l;
    qt[id]++;
  endtask

  task automatic push_msg(input int id, input int base, input int len);
    for (int k = 0; k < len; k++) push_byte(id, 8'(base + k), (k == len - 1));
  endtask

  // Whole-transaction prediction: visit non-empty requesters in rotating order,
  // each grant taking bytes until a message end or MB bytes.
  task automatic build_model();
    int h [N];
    int p, g, cnt;
    bit l;
    for (int i = 0; i < N; i++) h[i] = qh[i];
    p = 0; exp_n = 0; exp_trunc = 0;
    forever begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (p + k) % N;
        if (g < 0 && h[c] < qt[c]) g = c;
      end
      if (g < 0) break;
      cnt = 0;
      do begin
        exp_id[exp_n] = g;
        exp_d[exp_n]  = qd[g][h[g]];
        l = ql[g][h[g]];
        h[g]++; exp_n++; cnt++;
      end while (!l && cnt < MB);
      if (!l) exp_trunc++;
      p = (g + 1) % N;
    end
  endtask

  task automatic drive();
    bit stalled;
    for (int i = 0; i < N; i++) begin
      stalled = (i == st_id) && (st_rem > 0);
      if (qh[i] < qt[i] && !stalled) begin
        req_valid[i] = 1'b1;
        req_data[i*DW +: DW] = qd[i][qh[i]];
        req_last[i] = ql[i][qh[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*DW +: DW] = 8'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    if (st_rem > 0) st_rem--;
    if (cyc >= lo_s && cyc < lo_e) tx_ready = 1'b0;
    else if (tr_rand) tx_ready = 1'($urandom);
    else tx_ready = 1'b1;
  endtask

  task automatic cycle();
    int hi;
    drive();
    @(negedge clk);
    if (cyc < TR) begin
      t_ga[cyc] = grant_active; t_gid[cyc] = int'(grant_id); t_txv[cyc] = tx_valid;
      t_txd[cyc] = tx_data; t_bt[cyc] = burst_trunc; t_rdy[cyc] = req_ready;
    end
    hi = -1;
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) hi = i;
    if (sb_en) begin
      total++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) begin
        bad++; $display("FAIL ready_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      if (prev_hold) begin
        total++;
        if (tx_valid !== 1'b1 || tx_data !== prev_d) begin
          bad++; $display("FAIL hold_stable: got v=%b d=%h, want v=1 d=%h", tx_valid, tx_data, prev_d);
        end
      end
      if (hi >= 0) begin
        total++;
        if (hs_k >= exp_n) begin
          bad++; $display("FAIL extra_hs: requester %0d byte %h beyond %0d expected", hi, req_data[hi*DW +: DW], exp_n);
        end else if (hi != exp_id[hs_k] || req_data[hi*DW +: DW] !== exp_d[hs_k] || int'(grant_id) != hi) begin
          bad++; $display("FAIL hs_order[%0d]: got id=%0d d=%h gid=%0d, want id=%0d d=%h",
                          hs_k, hi, req_data[hi*DW +: DW], grant_id, exp_id[hs_k], exp_d[hs_k]);
        end
        if (hs_k < XD) begin hs_id[hs_k] = hi; hs_cyc[hs_k] = cyc; end
        hs_k++;
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        total++;
        if (tx_k >= exp_n) begin
          bad++; $display("FAIL extra_tx: got %h, want none", tx_data);
        end else if (tx_data !== exp_d[tx_k]) begin
          bad++; $display("FAIL tx_order[%0d]: got %h, want %h", tx_k, tx_data, exp_d[tx_k]);
        end
        tx_k++;
      end
      if (burst_trunc === 1'b1) begin
        trunc_seen++;
        total++;
        if (grant_active !== 1'b0) begin
          bad++; $display("FAIL trunc_idle: grant_active=%b, want 0", grant_active);
        end
      end
    end
    prev_hold = (tx_valid === 1'b1) && !tx_ready;
    prev_d = tx_data;
    @(posedge clk);
    #1;
    if (hi >= 0) begin
      qh[hi]++;
      if (hi == st_id) begin
        st_cnt++;
        if (st_cnt == st_after) st_rem = st_len;
      end
    end
    cyc++;
  endtask

  task automatic run(input int budget);
    build_model();
    hs_k = 0; tx_k = 0; trunc_seen = 0; cyc = 0;
    while (tx_k < exp_n && cyc < budget) cycle();
    total++;
    if (tx_k != exp_n) begin
      bad++; $display("FAIL drain: bytes out %0d, want %0d within %0d cycles", tx_k, exp_n, budget);
    end
    repeat (2) cycle();
    total++;
    if (grant_active !== 1'b0 || tx_valid !== 1'b0) begin
      bad++; $display("FAIL idle_end: got ga=%b tv=%b, want 0 0", grant_active, tx_valid);
    end
    total++;
    if (trunc_seen != exp_trunc) begin
      bad++; $display("FAIL trunc_count: got %0d, want %0d", trunc_seen, exp_trunc);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req_valid = '1; req_last = N'($urandom); req_data = $urandom; tx_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
    total++; if (grant_active !== 1'b0) begin bad++; $display("FAIL rst_grant_active: got %b want 0", grant_active); end
    total++; if (burst_trunc !== 1'b0) begin bad++; $display("FAIL rst_burst_trunc: got %b want 0", burst_trunc); end
  endtask

  task automatic test_single();
    do_reset();
    push_byte(2, 8'h41, 0); push_byte(2, 8'h42, 0); push_byte(2, 8'h43, 1);
    run(50);
    total++;
    if (t_ga[0] !== 1'b0 || t_ga[1] !== 1'b1 || t_rdy[1] !== 4'b0100) begin
      bad++; $display("FAIL single_latency: got ga0=%b ga1=%b rdy1=%b, want 0 1 0100", t_ga[0], t_ga[1], t_rdy[1]);
    end
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (t_gid[c] != 2 || t_ga[c] !== (c <= 3)) begin
        bad++; $display("FAIL single_grant[%0d]: got gid=%0d ga=%b, want 2 %b", c, t_gid[c], t_ga[c], (c <= 3));
      end
    end
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (t_txv[c] !== 1'b1 || t_txd[c] !== 8'(8'h41 + c - 2)) begin
        bad++; $display("FAIL single_tx[%0d]: got v=%b d=%h, want 1 %h", c, t_txv[c], t_txd[c], 8'(8'h41 + c - 2));
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push_byte(i, 8'(8'hA0 + i), 1);
    run(100);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (hs_id[k] != k % N || (k > 0 && hs_cyc[k] - hs_cyc[k-1] != 2)) begin
        bad++; $display("FAIL rr[%0d]: got id=%0d gap=%0d, want id=%0d gap=2",
                        k, hs_id[k], (k > 0) ? hs_cyc[k] - hs_cyc[k-1] : 2, k % N);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_byte(0, 8'h55, 0); push_byte(0, 8'h56, 0); push_byte(0, 8'h57, 0); push_byte(0, 8'h58, 1);
    lo_s = 2; lo_e = 12;
    run(100);
    for (int c = 2; c < 12; c++) begin
      total++;
      if (t_txv[c] !== 1'b1 || t_txd[c] !== 8'h55 || t_rdy[c] !== 4'b0000) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b d=%h rdy=%b, want 1 55 0000", c, t_txv[c], t_txd[c], t_rdy[c]);
      end
    end
  endtask

  task automatic test_truncation();
    int tc;
    do_reset();
    push_msg(1, 0, 20);
    push_msg(3, 8'hC0, 2);
    run(200);
    tc = hs_cyc[15] + 1;
    total++;
    if (trunc_seen != 1 || t_bt[tc] !== 1'b1 || t_ga[tc] !== 1'b0) begin
      bad++; $display("FAIL trunc_pulse: got n=%0d bt=%b ga=%b, want 1 1 0", trunc_seen, t_bt[tc], t_ga[tc]);
    end
    total++;
    if (hs_id[16] != 3 || hs_id[17] != 3 || hs_id[18] != 1 || hs_cyc[15] - hs_cyc[0] != 15) begin
      bad++; $display("FAIL trunc_order: got %0d %0d %0d span=%0d, want 3 3 1 15",
                      hs_id[16], hs_id[17], hs_id[18], hs_cyc[15] - hs_cyc[0]);
    end
    do_reset();
    push_msg(1, 8'h20, 16);
    run(100);
    total++;
    if (trunc_seen != 0) begin
      bad++; $display("FAIL trunc_exact: got %0d pulses, want 0", trunc_seen);
    end
  endtask

  task automatic test_stall();
    int c0;
    do_reset();
    push_msg(0, 8'h10, 4);
    push_msg(1, 8'h20, 2);
    st_id = 0; st_after = 2; st_len = 5;
    run(100);
    c0 = hs_cyc[1];
    for (int c = c0 + 1; c <= c0 + 5; c++) begin
      total++;
      if (t_gid[c] != 0 || t_ga[c] !== 1'b1 || t_rdy[c] !== 4'b0000) begin
        bad++; $display("FAIL stall_hold[%0d]: got gid=%0d ga=%b rdy=%b, want 0 1 0000", c, t_gid[c], t_ga[c], t_rdy[c]);
      end
    end
    total++;
    if (hs_id[3] != 0 || hs_id[4] != 1 || hs_cyc[2] != c0 + 6) begin
      bad++; $display("FAIL stall_order: got id3=%0d id4=%0d resume=%0d, want 0 1 %0d", hs_id[3], hs_id[4], hs_cyc[2], c0 + 6);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_byte(2, 8'h99, 1);
    run(50);
    sb_en = 0;
    clear_ctl();
    lo_s = 0; lo_e = 1 << 20;
    push_msg(3, 8'hD0, 5);
    cyc = 0;
    repeat (4) cycle();
    total++;
    if (tx_valid !== 1'b1 || grant_active !== 1'b1 || grant_id !== 2'd3) begin
      bad++; $display("FAIL rstmid_pre: got tv=%b ga=%b gid=%0d, want 1 1 3", tx_valid, grant_active, grant_id);
    end
    rstn = 1'b0;
    cycle();
    total++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || req_ready !== 4'b0000) begin
      bad++; $display("FAIL rstmid_tx: got tv=%b d=%h rdy=%b, want 0 00 0000", tx_valid, tx_data, req_ready);
    end
    total++;
    if (grant_id !== 2'd0 || grant_active !== 1'b0 || burst_trunc !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctl: got gid=%0d ga=%b bt=%b, want 0 0 0", grant_id, grant_active, burst_trunc);
    end
    rstn = 1'b1;
    clear_ctl();
    sb_en = 1;
    push_byte(3, 8'hB3, 1);
    push_byte(0, 8'hB0, 1);
    run(50);
    total++;
    if (hs_id[0] != 0) begin
      bad++; $display("FAIL rstmid_first: got first grantee %0d, want 0", hs_id[0]);
    end
  endtask

  task automatic test_random();
    int nmsg, id, len;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      tr_rand = 1;
      nmsg = $urandom_range(10, 4);
      for (int m = 0; m < nmsg; m++) begin
        id  = $urandom_range(N - 1, 0);
        len = $urandom_range(24, 1);
        for (int k = 0; k < len; k++) push_byte(id, 8'($urandom), (k == len - 1));
      end
      run(6000);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, message-atomic arbiter that shares one UART_LITE_TX byte datapath among `NUM_REQ` byte-stream requesters. It sits between the requesters (command responders, log sources) and the UART TX core's byte input. It grants one requester at a time and passes that requester's bytes through a one-entry output register. A grant is held until the message-final byte is sent, or until `MAX_BURST` bytes have gone, whichever comes first.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `MAX_BURST`, default 16: maximum bytes per grant before forced rotation, at least 1.
- `ACLK`  in  1: the single clock; all logic is on its rising edge.
- `ARESETN`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ: per-requester byte valid.
- `req_data`  in  NUM_REQ*DATA_W: requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ: the current byte is the last of its message.
- `req_ready`  out  NUM_REQ: per-requester byte accept.
- `tx_data`  out  DATA_W: byte to the UART TX core.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: the TX core accepts the byte.
- `grant_id`  out  clog2(NUM_REQ): index of the current or most recent grantee.
- `grant_active`  out  1: the FSM is in SEND.
- `burst_trunc`  out  1: one-cycle pulse when a grant is released by `MAX_BURST`.

## Operation
- FSM states are IDLE and SEND.
- **IDLE:**
  - If any `req_valid` is high, select the first set bit searching upward from `ptr`, with wrap at NUM_REQ-1 back to 0.
  - Register the selection into `grant_id`, clear `cnt`, and go to SEND.
  - If no `req_valid` is high, stay in IDLE.
- **SEND:**
  - `req_ready[grant_id]` = `req_valid[grant_id]` && (!`tx_valid` || `tx_ready`).
  - All other `req_ready` bits are 0.
  - A requester handshake loads `tx_data` from the grantee's data, sets `tx_valid`, and increments `cnt`.
- **Output register:**
  - `tx_valid` clears on `tx_ready` when no new byte loads in the same cycle.
  - A simultaneous drain and load keeps `tx_valid` high with the new data.
  - The register keeps draining in IDLE.
- **Release:** on a requester handshake with `req_last`=1, or with `cnt`+1 == MAX_BURST:
  - go to IDLE next cycle;
  - set `ptr` = (`grant_id`+1) mod NUM_REQ.
  - A release on `MAX_BURST` with `req_last`=0 pulses `burst_trunc` for 1 cycle.
  - A release where `req_last`=1 and the count hits `MAX_BURST` together is a normal release; `burst_trunc` stays 0.
- **Message atomicity:** if the grantee drops `req_valid` mid-message, the grant is held indefinitely. There is no timeout, and no other requester's bytes are interleaved.
- **Width rules:**
  - `cnt` is clog2(MAX_BURST+1) bits.
  - `ptr` and `grant_id` are clog2(NUM_REQ) bits with explicit mod-NUM_REQ wrap; this covers non-power-of-2 NUM_REQ.
- `tx_ready` while `tx_valid`=0 is ignored.
- `req_last` is sampled only on a handshake.

## Timing
- **Reset values, one cycle after ARESETN sampled low:**
  - state IDLE;
  - `tx_valid`=0, `tx_data`=0;
  - `req_ready`=0;
  - `grant_id`=0, `grant_active`=0;
  - `burst_trunc`=0;
  - `ptr`=0, `cnt`=0.
- **Reset mid-operation:** any byte held in the output register is discarded; the grant is lost.
- **Arbitration latency:** `req_valid` rising in IDLE at cycle N gives `grant_active`=1 at N+1 and the first `req_ready` at N+1. `tx_valid` goes high at N+2.
- **Throughput in SEND:** 1 byte per cycle with `tx_ready` held high.
- **Inter-message gap:** last-byte handshake at cycle M gives IDLE at M+1 and the next grant at M+2. This leaves exactly 1 bubble cycle on `req_ready` between grants.
- **Output stability:** `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
- **`burst_trunc`:** asserted in the cycle after the truncating handshake, coincident with IDLE.

## Test plan
- **Single message:** after reset, requester 2 sends 0x41, 0x42, 0x43 with `req_last` on 0x43, and `tx_ready`=1 -> `tx_data` shows 41, 42, 43 on consecutive cycles. `grant_id`=2 throughout. `grant_active` falls the cycle after the 0x43 handshake. `burst_trunc` stays 0.
- **Round-robin and wrap:** all four requesters hold one-byte messages 0xA0..0xA3 continuously after reset -> grant order is 0, 1, 2, 3, 0, 1, 2, 3, with one bubble cycle between grants and `ptr` wrapping from 3 to 0.
- **Backpressure:** hold `tx_ready`=0 for 10 cycles while `tx_valid`=1 with 0x55 and the grantee still valid -> `tx_data` holds 0x55 and `req_ready`=0 for all 10 cycles. After release, every byte appears exactly once, in order.
- **Truncation:** MAX_BURST=16, requester 1 sends 20 bytes 0x00..0x13 (`req_last` on 0x13) and requester 3 has a 2-byte message pending -> output is 0x00..0x0F, then a `burst_trunc` pulse, then requester 3's 2 bytes, then 0x10..0x13. Repeat with a 16-byte message ending in `req_last` -> no `burst_trunc`.
- **Mid-message stall:** requester 0 drops `req_valid` for 5 cycles after its 2nd byte while requester 1 is valid -> `grant_id` stays 0, no requester-1 byte appears until requester 0's `req_last` byte is accepted.
- **Reset mid-message:** drive ARESETN low for one cycle while `tx_valid`=1 during a grant -> every output takes its reset value on the next edge. The next arbitration starts from requester 0.
